multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Parametrised multi-cycle control unit for the RISC-V core; the next generation of the shared type/opcode definitions.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Supports variable-latency instruction and data memories via request/acknowledge handshakes.
- Adds `lui`/`jal`, a memory-wait timeout, a sticky trap, and a retired-instruction counter to the addi/bne/lw/sw set.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width
- ALU_WIDTH, 3, ALU command width
- IMM_WIDTH, 3, immediate-format select width
- TIMEOUT, 15, max wait cycles in FETCH/MEM before trap (1..255)
- CNT_WIDTH, 16, retired counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- instr  in  DATA_WIDTH  instruction held by datapath IR; valid from DECODE onward
- instr_req  out  1  instruction fetch request
- instr_valid  in  1  fetch acknowledge
- ir_en  out  1  latch instruction into IR
- eq  in  1  ALU equality flag (rs1 == rs2)
- mem_req  out  1  data memory request
- mem_we  out  1  data memory write strobe
- mem_ack  in  1  data memory acknowledge
- alu_ctrl  out  ALU_WIDTH  ALU command (SUM 000, SUB 001)
- alu_src  out  1  0 = rs2, 1 = immediate
- imm_src  out  IMM_WIDTH  Imm 0, UpperImm 1, Store 2, Branch 3, Jump 4
- result_src  out  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate
- reg_we  out  1  register file write enable
- pc_en  out  1  PC update enable
- pc_src  out  2  0 = PC+4, 1 = PC+imm
- trap  out  1  sticky illegal-opcode or timeout flag
- timeout  out  1  sticky; set only when the trap cause is a timeout
- retired  out  CNT_WIDTH  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Opcode = instr[6:0].
- IDLE: all outputs 0. Moves to FETCH on the first clock after rst deasserts.
- FETCH:
  - instr_req = 1 until instr_valid.
  - On instr_valid: ir_en = 1 for that cycle, then go to DECODE.
- DECODE:
  - Legal opcodes go to EXEC: addi 0010011, lui 0110111, bne 1100011, jal 1101111, lw 0000011, sw 0100011.
  - Any other opcode goes to TRAP.
- EXEC:
  - addi: SUM, alu_src = 1, imm_src = Imm, then WB.
  - lui: imm_src = UpperImm, then WB.
  - bne: SUB, alu_src = 0, imm_src = Branch, pc_en = 1. pc_src = 1 if eq = 0, else 0. Retire, then FETCH.
  - jal: imm_src = Jump, result_src = 2, reg_we = 1, pc_en = 1, pc_src = 1. Retire, then FETCH.
  - lw/sw: SUM, alu_src = 1, imm_src = Imm (lw) or Store (sw), then MEM.
- MEM:
  - mem_req = 1 until mem_ack. mem_we = 1 for sw.
  - lw + ack: go to WB.
  - sw + ack: pc_en = 1, pc_src = 0, retire, then FETCH.
- WB:
  - reg_we = 1, pc_en = 1, pc_src = 0, retire, then FETCH.
  - result_src = 0 for addi, 1 for lw, 3 for lui.
- Retire: retired increments by 1 on every cycle where pc_en = 1. Wraps 2^CNT_WIDTH-1 to 0.
- Wait timer:
  - Clears on entry to FETCH or MEM and counts each cycle without an acknowledge.
  - The TIMEOUT-th consecutive unacknowledged cycle goes to TRAP with timeout = 1.
  - An acknowledge arriving on that same cycle wins: normal progression, no timeout.
- TRAP: all enables and requests 0, trap = 1. Held until rst.
- Outputs not listed for a state are 0.

## Timing
- Outputs are combinational from state, opcode and eq/acks. State and counters are registered.
- Minimum latency with ack in the first request cycle:
  - bne/jal: 3 cycles
  - addi/lui/sw: 4 cycles
  - lw: 5 cycles
- Each extra wait cycle adds 1 cycle.
- Reset values: state IDLE, retired 0, trap 0, timeout 0, timer 0, all combinational outputs 0.
- rst mid-instruction: immediate return to IDLE. Any pending request drops the same cycle; no partial retire.
- instr_valid/mem_ack outside FETCH/MEM are ignored.

## Structure
- Shared package holds:
  - ctrl_state enum
  - extended opcode enum (adds lui, jal)
  - pc_src and result_src enums
  - existing alu_ctrl and instr_format enums
- Sub-module wait_timer: clear, count enable, TIMEOUT parameter, expired output.

## Test plan
- Reset, then 0x00500093 (addi x1,x0,5), ack immediately → IDLE→FETCH→DECODE→EXEC→WB. WB has reg_we = 1, result_src = 0, alu_ctrl = 000. retired = 1.
- bne with eq = 0, then bne with eq = 1 → pc_src = 1, then 0. pc_en in EXEC, 3 cycles each. retired = 2.
- 0x0000a103 (lw) with mem_ack delayed 4 cycles → mem_req high for 5 cycles, then WB with result_src = 1. Total 9 cycles.
- 0x00000000 → TRAP after DECODE, trap = 1, timeout = 0. Outputs stay 0 for 20 cycles; rst clears trap.
- 0x0020a023 (sw), TIMEOUT = 15, mem_ack never asserts → TRAP after 15 MEM cycles, timeout = 1. Same test with ack on cycle 15 → retires normally.
- CNT_WIDTH = 4, run 17 jal → retired wraps to 1. Assert rst during MEM → mem_req drops immediately, retired = 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared type and opcode definitions for the multi-cycle RISC-V control unit.
// Adds lui/jal opcodes, pc/result source selects and the controller state set.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } ctrl_state_t;

   typedef enum logic [6:0] {
      OP_LW   = 7'b0000011,
      OP_ADDI = 7'b0010011,
      OP_SW   = 7'b0100011,
      OP_LUI  = 7'b0110111,
      OP_BNE  = 7'b1100011,
      OP_JAL  = 7'b1101111
   } opcode_t;

   typedef enum logic [2:0] {
      ALU_SUM = 3'b000,
      ALU_SUB = 3'b001
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      FMT_IMM    = 3'd0,
      FMT_UPPER  = 3'd1,
      FMT_STORE  = 3'd2,
      FMT_BRANCH = 3'd3,
      FMT_JUMP   = 3'd4
   } instr_format_t;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_TARGET = 2'd1
   } pc_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2,
      RES_IMM = 2'd3
   } result_src_t;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_LW, OP_ADDI, OP_SW, OP_LUI, OP_BNE, OP_JAL: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory request/acknowledge handshakes of the controller.
interface multicycle_ctrl_if;

   logic instr_req;
   logic instr_valid;
   logic mem_req;
   logic mem_we;
   logic mem_ack;

   modport master (
      output instr_req, mem_req, mem_we,
      input  instr_valid, mem_ack
   );

   modport slave (
      input  instr_req, mem_req, mem_we,
      output instr_valid, mem_ack
   );

endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Counts consecutive unacknowledged memory-wait cycles; expired flags the
// TIMEOUT-th such cycle while it is happening.
module wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en) begin
         count <= count + 8'd1;
      end
   end

   assign expired = count_en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// handshaked memories, wait timeout, sticky trap and retired counter.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ALU_WIDTH  = 3,
   parameter int IMM_WIDTH  = 3,
   parameter int TIMEOUT    = 15,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  eq,
   multicycle_ctrl_if.master     bus,
   output logic                  ir_en,
   output logic [ALU_WIDTH-1:0]  alu_ctrl,
   output logic                  alu_src,
   output logic [IMM_WIDTH-1:0]  imm_src,
   output logic [1:0]            result_src,
   output logic                  reg_we,
   output logic                  pc_en,
   output logic [1:0]            pc_src,
   output logic                  trap,
   output logic                  timeout,
   output logic [CNT_WIDTH-1:0]  retired
);

   ctrl_state_t state, next_state;
   logic [6:0]  opcode;
   logic        waiting, ack, timer_expired, timeout_q;
   logic        unused_instr_bits;

   assign opcode            = instr[6:0];
   assign unused_instr_bits = ^instr[DATA_WIDTH-1:7];

   assign waiting = (state == ST_FETCH) || (state == ST_MEM);
   assign ack     = (state == ST_FETCH) ? bus.instr_valid : bus.mem_ack;

   wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (!(waiting && !ack)),
      .count_en (waiting && !ack),
      .expired  (timer_expired)
   );

   // The timeout flag only latches on an expiry, which always sends the FSM to TRAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         retired   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state <= next_state;
         if (pc_en) retired <= retired + CNT_WIDTH'(1);
         if (timer_expired) timeout_q <= 1'b1;
      end
   end

   assign trap    = (state == ST_TRAP);
   assign timeout = timeout_q;

   always_comb begin
      next_state    = state;
      bus.instr_req = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      ir_en         = 1'b0;
      alu_ctrl      = '0;
      alu_src       = 1'b0;
      imm_src       = '0;
      result_src    = RES_ALU;
      reg_we        = 1'b0;
      pc_en         = 1'b0;
      pc_src        = PC_PLUS4;
      case (state)
         ST_IDLE: next_state = ST_FETCH;
         ST_FETCH: begin
            bus.instr_req = 1'b1;
            if (bus.instr_valid) begin
               ir_en      = 1'b1;
               next_state = ST_DECODE;
            end else if (timer_expired) begin
               next_state = ST_TRAP;
            end
         end
         ST_DECODE: next_state = is_legal(opcode) ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            case (opcode)
               OP_ADDI: begin
                  alu_ctrl   = ALU_WIDTH'(ALU_SUM);
                  alu_src    = 1'b1;
                  imm_src    = IMM_WIDTH'(FMT_IMM);
                  next_state = ST_WB;
               end
               OP_LUI: begin
                  imm_src    = IMM_WIDTH'(FMT_UPPER);
                  next_state = ST_WB;
               end
               OP_BNE: begin
                  alu_ctrl   = ALU_WIDTH'(ALU_SUB);
                  imm_src    = IMM_WIDTH'(FMT_BRANCH);
                  pc_en      = 1'b1;
                  pc_src     = eq ? PC_PLUS4 : PC_TARGET;
                  next_state = ST_FETCH;
               end
               OP_JAL: begin
                  imm_src    = IMM_WIDTH'(FMT_JUMP);
                  result_src = RES_PC4;
                  reg_we     = 1'b1;
                  pc_en      = 1'b1;
                  pc_src     = PC_TARGET;
                  next_state = ST_FETCH;
               end
               OP_LW, OP_SW: begin
                  alu_ctrl   = ALU_WIDTH'(ALU_SUM);
                  alu_src    = 1'b1;
                  imm_src    = (opcode == OP_SW) ? IMM_WIDTH'(FMT_STORE) : IMM_WIDTH'(FMT_IMM);
                  next_state = ST_MEM;
               end
               default: next_state = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = (opcode == OP_SW);
            if (bus.mem_ack) begin
               if (opcode == OP_SW) begin
                  pc_en      = 1'b1;
                  next_state = ST_FETCH;
               end else begin
                  next_state = ST_WB;
               end
            end else if (timer_expired) begin
               next_state = ST_TRAP;
            end
         end
         ST_WB: begin
            reg_we     = 1'b1;
            pc_en      = 1'b1;
            next_state = ST_FETCH;
            case (opcode)
               OP_LW:   result_src = RES_MEM;
               OP_LUI:  result_src = RES_IMM;
               default: result_src = RES_ALU;
            endcase
         end
         ST_TRAP: next_state = ST_TRAP;
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: walks each opcode through
// its state sequence, plus trap, timeout, counter wrap and mid-instruction reset.
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_BNE  = 32'h00209463;
   localparam logic [31:0] I_LW   = 32'h0000a103;
   localparam logic [31:0] I_SW   = 32'h0020a023;
   localparam logic [31:0] I_JAL  = 32'h0000006f;
   localparam logic [31:0] I_LUI  = 32'h000010b7;
   localparam logic [31:0] I_BAD  = 32'h00000000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [31:0]      instr = '0;
   logic             eq = 1'b0;
   logic             ir_en, alu_src, reg_we, pc_en, trap, timeout;
   logic [2:0]       alu_ctrl, imm_src;
   logic [1:0]       result_src, pc_src;
   logic [CNT_W-1:0] retired;
   logic [18:0]      obs;

   int checks   = 0;
   int failures = 0;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(
      .DATA_WIDTH (32),
      .ALU_WIDTH  (3),
      .IMM_WIDTH  (3),
      .TIMEOUT    (15),
      .CNT_WIDTH  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .eq         (eq),
      .bus        (bus.master),
      .ir_en      (ir_en),
      .alu_ctrl   (alu_ctrl),
      .alu_src    (alu_src),
      .imm_src    (imm_src),
      .result_src (result_src),
      .reg_we     (reg_we),
      .pc_en      (pc_en),
      .pc_src     (pc_src),
      .trap       (trap),
      .timeout    (timeout),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   assign obs = {bus.instr_req, ir_en, bus.mem_req, bus.mem_we, alu_ctrl, alu_src,
                 imm_src, result_src, reg_we, pc_en, pc_src, trap, timeout};

   // Packs an expected control word in the same field order as obs.
   function automatic logic [18:0] mk(input int ireq, input int iren, input int mreq,
                                      input int mwe, input int alu, input int asrc,
                                      input int imm, input int res, input int rwe,
                                      input int pen, input int psrc, input int tr,
                                      input int to);
      return {1'(ireq), 1'(iren), 1'(mreq), 1'(mwe), 3'(alu), 1'(asrc), 3'(imm),
              2'(res), 1'(rwe), 1'(pen), 2'(psrc), 1'(tr), 1'(to)};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic iv, input logic ack, input logic e);
      bus.instr_valid = iv;
      bus.mem_ack     = ack;
      eq              = e;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Leaves the DUT in IDLE at posedge+1 with all inputs quiet.
   task automatic do_reset();
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("reset_outputs", 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,0,0)));
      check_output("reset_retired", 32'(retired), 32'd0);
      cycle();
      rst = 1'b0;
   endtask

   // From IDLE or FETCH entry: acknowledged fetch, then DECODE; ends at EXEC.
   task automatic fetch_decode(input string tag, input logic [31:0] word);
      instr = word;
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output({tag, "_fetch"}, 32'(obs), 32'(mk(1,1,0,0,0,0,0,0,0,0,0,0,0)));
      cycle();
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output({tag, "_decode"}, 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,0,0)));
      cycle();
   endtask

   initial begin
      bus.instr_valid = 1'b0;
      bus.mem_ack     = 1'b0;
      $display("[TB] start");

      // addi: FETCH, DECODE, EXEC, WB
      do_reset();
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("idle_outputs", 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,0,0)));
      cycle();
      fetch_decode("addi", I_ADDI);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("addi_exec", 32'(obs), 32'(mk(0,0,0,0,0,1,0,0,0,0,0,0,0)));
      cycle();
      check_output("addi_wb", 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,1,1,0,0,0)));
      cycle();
      check_output("addi_retired", 32'(retired), 32'd1);
      check_output("addi_back_fetch", 32'(obs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0,0,0)));

      // bne taken, then not taken
      do_reset();
      cycle();
      fetch_decode("bne_ne", I_BNE);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("bne_ne_exec", 32'(obs), 32'(mk(0,0,0,0,1,0,3,0,0,1,1,0,0)));
      cycle();
      fetch_decode("bne_eq", I_BNE);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("bne_eq_exec", 32'(obs), 32'(mk(0,0,0,0,1,0,3,0,0,1,0,0,0)));
      cycle();
      check_output("bne_retired", 32'(retired), 32'd2);

      // lw with four wait cycles before mem_ack
      fetch_decode("lw", I_LW);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("lw_exec", 32'(obs), 32'(mk(0,0,0,0,0,1,0,0,0,0,0,0,0)));
      cycle();
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0);
         check_output("lw_mem_wait", 32'(obs), 32'(mk(0,0,1,0,0,0,0,0,0,0,0,0,0)));
         cycle();
      end
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("lw_mem_ack", 32'(obs), 32'(mk(0,0,1,0,0,0,0,0,0,0,0,0,0)));
      cycle();
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("lw_wb", 32'(obs), 32'(mk(0,0,0,0,0,0,0,1,1,1,0,0,0)));
      cycle();
      check_output("lw_retired", 32'(retired), 32'd3);

      // illegal opcode traps and holds until reset
      fetch_decode("bad", I_BAD);
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'(i), 1'(i + 1), 1'b0);
         check_output("trap_hold", 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,1,0)));
         cycle();
      end
      check_output("trap_retired", 32'(retired), 32'd3);
      do_reset();
      check_output("trap_cleared", 32'(trap), 32'd0);

      // sw with no acknowledge: trap with timeout after 15 MEM cycles
      cycle();
      fetch_decode("sw_to", I_SW);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("sw_exec", 32'(obs), 32'(mk(0,0,0,0,0,1,2,0,0,0,0,0,0)));
      cycle();
      for (int i = 0; i < 15; i++) begin
         check_output("sw_mem_wait", 32'(obs), 32'(mk(0,0,1,1,0,0,0,0,0,0,0,0,0)));
         cycle();
      end
      check_output("sw_timeout_trap", 32'(obs), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,1,1)));

      // same sw, acknowledged on the 15th MEM cycle
      do_reset();
      cycle();
      fetch_decode("sw_ok", I_SW);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < 14; i++) cycle();
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("sw_late_ack", 32'(obs), 32'(mk(0,0,1,1,0,0,0,0,0,1,0,0,0)));
      cycle();
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("sw_late_fetch", 32'(obs), 32'(mk(1,0,0,0,0,0,0,0,0,0,0,0,0)));
      check_output("sw_late_retired", 32'(retired), 32'd1);

      // 17 jal on a 4-bit counter wrap to 1
      do_reset();
      cycle();
      for (int i = 0; i < 17; i++) begin
         fetch_decode("jal", I_JAL);
         apply_stimulus(1'b0, 1'b0, 1'b0);
         check_output("jal_exec", 32'(obs), 32'(mk(0,0,0,0,0,0,4,2,1,1,1,0,0)));
         cycle();
      end
      check_output("jal_wrap_retired", 32'(retired), 32'd1);

      // lui
      fetch_decode("lui", I_LUI);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("lui_exec", 32'(obs), 32'(mk(0,0,0,0,0,0,1,0,0,0,0,0,0)));
      cycle();
      check_output("lui_wb", 32'(obs), 32'(mk(0,0,0,0,0,0,0,3,1,1,0,0,0)));
      cycle();
      check_output("lui_retired", 32'(retired), 32'd2);

      // reset asserted mid-MEM drops the request at once
      fetch_decode("lw_rst", I_LW);
      cycle();
      check_output("rst_pre_mem_req", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      #1;
      check_output("rst_mem_req_drop", 32'(bus.mem_req), 32'd0);
      check_output("rst_retired_clear", 32'(retired), 32'd0);
      cycle();
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
